// File: rtl/vram_sys_arb_if.sv
// rtl/vram_sys_arb_if.sv - requester, vram and read-return signals of the vram system port arbiter
interface vram_sys_arb_if #(
    parameter int WORD  = 32,
    parameter int ADDRW = 14
);
    logic             er_req;
    logic [ADDRW-1:0] er_addr;
    logic [WORD-1:0]  er_wmask;
    logic [WORD-1:0]  er_din;
    logic             er_ack;
    logic             er_rvalid;

    logic             cpu_req;
    logic [ADDRW-1:0] cpu_addr;
    logic [WORD-1:0]  cpu_wmask;
    logic [WORD-1:0]  cpu_din;
    logic             cpu_ack;
    logic             cpu_rvalid;

    logic [WORD-1:0]  rd_dout;
    logic [ADDRW-1:0] vram_addr;
    logic [WORD-1:0]  vram_wmask;
    logic [WORD-1:0]  vram_din;
    logic [WORD-1:0]  vram_dout;

    modport slave (
        input  er_req, er_addr, er_wmask, er_din,
        input  cpu_req, cpu_addr, cpu_wmask, cpu_din,
        input  vram_dout,
        output er_ack, er_rvalid, cpu_ack, cpu_rvalid,
        output rd_dout, vram_addr, vram_wmask, vram_din
    );

    modport master (
        output er_req, er_addr, er_wmask, er_din,
        output cpu_req, cpu_addr, cpu_wmask, cpu_din,
        output vram_dout,
        input  er_ack, er_rvalid, cpu_ack, cpu_rvalid,
        input  rd_dout, vram_addr, vram_wmask, vram_din
    );
endinterface

// File: rtl/vram_sys_arb.sv
// rtl/vram_sys_arb.sv - vram system port arbiter: Earthrise priority, CPU starvation guard, read-return routing
module vram_sys_arb #(
    parameter int WORD     = 32,
    parameter int ADDRW    = 14,
    parameter int RD_LAT   = 2,
    parameter int MAX_WAIT = 8
) (
    input  logic          clk_sys,
    input  logic          rst_sys,
    vram_sys_arb_if.slave bus
);
    localparam logic [7:0]       MAX_WAIT_W = 8'(MAX_WAIT);
    localparam logic [WORD-1:0]  WORD_ZERO  = '0;
    localparam logic [ADDRW-1:0] ADDR_ZERO  = '0;

    logic             force_cpu;
    logic             cpu_gnt;
    logic             er_gnt;
    logic             rd_issue;
    logic [ADDRW-1:0] mux_addr;
    logic [WORD-1:0]  mux_wmask;
    logic [WORD-1:0]  mux_din;
    logic [7:0]       wait_q, wait_d;
    // Each stage holds {valid, owner}; owner 1 = CPU, 0 = Earthrise.
    logic [1:0]       pipe_q [RD_LAT];
    logic [1:0]       pipe_d [RD_LAT];

    always_comb begin
        force_cpu = (wait_q == MAX_WAIT_W);
        cpu_gnt   = !rst_sys && bus.cpu_req && (!bus.er_req || force_cpu);
        er_gnt    = !rst_sys && bus.er_req && !cpu_gnt;
    end

    always_comb begin
        mux_addr  = ADDR_ZERO;
        mux_wmask = WORD_ZERO;
        mux_din   = WORD_ZERO;
        if (cpu_gnt) begin
            mux_addr  = bus.cpu_addr;
            mux_wmask = bus.cpu_wmask;
            mux_din   = bus.cpu_din;
        end else if (er_gnt) begin
            mux_addr  = bus.er_addr;
            mux_wmask = bus.er_wmask;
            mux_din   = bus.er_din;
        end
        rd_issue = (cpu_gnt || er_gnt) && (mux_wmask == WORD_ZERO);
    end

    always_comb begin
        wait_d = wait_q;
        if (!bus.cpu_req || cpu_gnt) begin
            wait_d = 8'd0;
        end else if (wait_q != MAX_WAIT_W) begin
            wait_d = wait_q + 8'd1;
        end
    end

    always_comb begin
        pipe_d[0] = {rd_issue, cpu_gnt};
        for (int i = 1; i < RD_LAT; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_ff @(posedge clk_sys or posedge rst_sys) begin
        if (rst_sys) begin
            wait_q <= 8'd0;
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_q[i] <= 2'b00;
            end
        end else begin
            wait_q <= wait_d;
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
        end
    end

    assign bus.er_ack     = er_gnt;
    assign bus.cpu_ack    = cpu_gnt;
    assign bus.vram_addr  = mux_addr;
    assign bus.vram_wmask = mux_wmask;
    assign bus.vram_din   = mux_din;
    assign bus.er_rvalid  = pipe_q[RD_LAT-1][1] && !pipe_q[RD_LAT-1][0];
    assign bus.cpu_rvalid = pipe_q[RD_LAT-1][1] &&  pipe_q[RD_LAT-1][0];
    assign bus.rd_dout    = bus.vram_dout;
endmodule

// File: doc/vram_sys_arb.md
Name: vram_sys_arb

Overview:
- Arbitrates the vram system port (clk_sys side) between two requesters: the Earthrise drawing engine and the CPU.
- Earthrise currently owns the port permanently. This block is the planned multiplexer that replaces the direct draw-address assignment.
- Earthrise has fixed priority. A starvation counter guarantees CPU service.
- The block also tracks outstanding reads through the vram read latency and routes the returned data valid to the requester that issued each read.

Parameters:
- WORD, 32, data and write-mask width (bits)
- ADDRW, 14, vram word address width (bits)
- RD_LAT, 2, vram read latency (cycles, ≥1)
- MAX_WAIT, 8, max consecutive cycles a pending CPU request may lose (1..255)

Ports:
- clk_sys  in  1  system clock
- rst_sys  in  1  reset, asynchronous, active-high
- er_req  in  1  Earthrise request
- er_addr  in  ADDRW  Earthrise word address
- er_wmask  in  WORD  Earthrise bit write mask; 0 = read
- er_din  in  WORD  Earthrise write data
- er_ack  out  1  Earthrise request accepted this cycle
- er_rvalid  out  1  read data valid for Earthrise
- cpu_req  in  1  CPU request
- cpu_addr  in  ADDRW  CPU word address
- cpu_wmask  in  WORD  CPU bit write mask; 0 = read
- cpu_din  in  WORD  CPU write data
- cpu_ack  out  1  CPU request accepted this cycle
- cpu_rvalid  out  1  read data valid for CPU
- rd_dout  out  WORD  read data (shared by both requesters, qualified by *_rvalid)
- vram_addr  out  ADDRW  to vram addr_sys
- vram_wmask  out  WORD  to vram wmask_sys
- vram_din  out  WORD  to vram din_sys
- vram_dout  in  WORD  from vram dout_sys

Behaviour:
- Handshake:
  - A requester raises req with addr, wmask and din stable and holds them until it samples ack=1 at a clock edge.
  - ack is combinational, in the same cycle as the grant. The transfer completes at that edge.
  - A requester may raise req again in the very next cycle (back-to-back, one transfer per cycle).
- Grant (combinational, from registered state):
  - CPU wins if cpu_req and (no er_req, or wait_cnt == MAX_WAIT).
  - Otherwise Earthrise wins if er_req.
  - At most one ack per cycle. No req means no ack.
- Port mux:
  - When granted, vram_addr, vram_wmask and vram_din come from the granted requester.
  - When idle: vram_wmask = 0, vram_addr = 0, vram_din = 0. A read of address 0 is harmless and ignored.
- wait_cnt (8-bit register):
  - Cleared when cpu_ack, or when cpu_req is low.
  - Incremented when cpu_req && !cpu_ack.
  - Saturates at MAX_WAIT.
  - The counter therefore forces a CPU grant on the (MAX_WAIT+1)th pending cycle at the latest.
- Read tracking:
  - A granted transfer with wmask == 0 is a read. Reads are pushed into an RD_LAT-deep shift pipe of {valid, owner}.
  - Read granted in cycle N: the owner's rvalid is high in cycle N+RD_LAT, for exactly one cycle.
  - rd_dout = vram_dout continuously. It is valid only when an rvalid is high.
  - Pipe advances every cycle. Reads are fully pipelined, one per cycle, with no stall.
- Writes:
  - Any nonzero wmask is a write. Only masked bits change in vram.
  - Writes produce no rvalid.
- Same-address hazards: reads return the vram's old/new behaviour as vram defines it. The arbiter does no forwarding.
- Reset (asynchronous, any time, including mid-operation):
  - wait_cnt = 0; read pipe valids = 0, so pending reads are discarded and no rvalid fires for them.
  - While rst_sys is high: er_ack = cpu_ack = 0, er_rvalid = cpu_rvalid = 0, vram_wmask = 0, vram_addr = 0, vram_din = 0.
  - First grant is possible in the first cycle after rst_sys deasserts.
- Width rules:
  - wait_cnt compares against MAX_WAIT truncated to 8 bits.
  - The RD_LAT pipe uses 2 bits per stage.

Test Plan:
- Earthrise only: er_req=1 for 4 cycles, writes to addr 0x0010..0x0013 with wmask 0x0000_00FF. Required: er_ack=1 each cycle; vram_wmask=0xFF with er_din passed through; cpu_ack=0; no rvalid.
- CPU read: cpu_req with addr 0x0100, wmask=0, Earthrise idle. Required: cpu_ack in cycle N; cpu_rvalid only in cycle N+2 with rd_dout = vram contents; er_rvalid stays 0.
- Starvation, MAX_WAIT=8: er_req held high continuously, cpu_req raised in cycle 0. Required: er_ack in cycles 0–7; cpu_ack in cycle 8 with er_ack=0 there; er_ack resumes in cycle 9; wait_cnt back to 0.
- Interleaved reads: alternating grants, ER read of 0x0001 in cycle N, CPU read of 0x0002 in cycle N+1. Required: er_rvalid in N+2 only, cpu_rvalid in N+3 only, each with the data of its own address.
- Reset mid-read: CPU read granted in cycle N, rst_sys pulsed high asynchronously in cycle N+1. Required: no cpu_rvalid in N+2; all acks and vram_wmask are 0 while reset is high; wait_cnt=0 after release.
- Idle: no requests for 10 cycles. Required: vram_wmask=0, vram_addr=0, both acks and both rvalids are 0 throughout.
